alu_md: RTL

ALU_MD -- requirements
Module: alu_md

---
 rtl/alu_md_if.sv | 27 ++
 rtl/alu_md.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_md_if.sv
// Request/response bundle between a client and the alu_md unit.
// The client drives the request side and out_ready; the unit drives
// in_ready, out_valid and the registered result/flags.
interface alu_md_if #(
    parameter int WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [4:0]       fn;
    logic [WIDTH-1:0] s_1;
    logic [WIDTH-1:0] s_2;
    logic             bubble;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [3:0]       flags;

    modport master (
        output in_valid, fn, s_1, s_2, bubble, out_ready,
        input  in_ready, out_valid, result, flags
    );

    modport slave (
        input  in_valid, fn, s_1, s_2, bubble, out_ready,
        output in_ready, out_valid, result, flags
    );
endinterface

// File: rtl/alu_md.sv
// alu_md: single-issue ALU with an iterative multiply/divide unit.
// Logic, add/sub and shift functions (fn 0-15) finish in one cycle;
// mul_lo/mul_hi/divu/remu (fn 16-19) take WIDTH shift-add or
// restoring-subtract steps. Result and flags {O,S,Z,C} are registered
// and held until the consumer takes them.
//
// state | meaning
// IDLE  | ready for a request (in_ready = 1)
// BUSY  | one mul/div step per cycle, WIDTH cycles in total
// DONE  | result/flags valid, waiting for out_ready
module alu_md #(
    parameter int WIDTH = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    alu_md_if.slave  bus
);
    localparam int MSB = WIDTH - 1;
    localparam int CW  = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic [1:0]       md_sel_q, md_sel_d;
    logic             bubble_q, bubble_d;
    logic [WIDTH-1:0] opd_q, opd_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic [WIDTH-1:0] s1, s2;
    logic             c_in;

    logic [WIDTH:0]   add_sum, sub_sum;
    logic             add_ovf, sub_ovf;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_o;

    logic [WIDTH:0]   mul_sum;
    logic [WIDTH-1:0] mul_hi_n, mul_lo_n;
    logic [WIDTH:0]   div_sh, div_diff;
    logic             div_ge;
    logic [WIDTH-1:0] div_r_n, div_q_n;
    logic [WIDTH-1:0] md_res;
    logic             md_c;

    assign s1   = bus.s_1;
    assign s2   = bus.s_2;
    assign c_in = flags_q[0];

    // Single-cycle function unit, evaluated on the live request inputs.
    // sub/subc compute s_2 + ~s_1 + cin so C is the no-borrow carry-out.
    always_comb begin
        alu_res = '0;
        alu_c   = 1'b0;
        alu_o   = 1'b0;
        add_sum = {1'b0, s1} + {1'b0, s2}
                + {{WIDTH{1'b0}}, (bus.fn == 5'd2) & c_in};
        sub_sum = {1'b0, s2} + {1'b0, ~s1}
                + {{WIDTH{1'b0}}, (bus.fn == 5'd6) | c_in};
        add_ovf = (s1[MSB] == s2[MSB]) && (add_sum[MSB] != s1[MSB]);
        sub_ovf = (s2[MSB] != s1[MSB]) && (sub_sum[MSB] != s2[MSB]);
        case (bus.fn)
            5'd0:  alu_res = ~(s1 & s2);
            5'd1,
            5'd2: begin
                alu_res = add_sum[MSB:0];
                alu_c   = add_sum[WIDTH];
                alu_o   = add_ovf;
            end
            5'd3:  alu_res = s1 | s2;
            5'd4,
            5'd6: begin
                alu_res = sub_sum[MSB:0];
                alu_c   = sub_sum[WIDTH];
                alu_o   = sub_ovf;
            end
            5'd5:  alu_res = s1 & s2;
            5'd7:  alu_res = s1 ^ s2;
            5'd8:  alu_res = ~s2;
            5'd9: begin
                alu_res = {s2[MSB-1:0], 1'b0};
                alu_c   = s2[MSB];
            end
            5'd10: begin
                alu_res = {1'b0, s2[MSB:1]};
                alu_c   = s2[0];
            end
            5'd11: begin
                alu_res = {s2[MSB-1:0], s2[MSB]};
                alu_c   = s2[MSB];
            end
            5'd12: begin
                alu_res = {s2[0], s2[MSB:1]};
                alu_c   = s2[0];
            end
            5'd13: begin
                alu_res = {s2[MSB], s2[MSB:1]};
                alu_c   = s2[0];
            end
            5'd14: begin
                alu_res = {c_in, s2[MSB:1]};
                alu_c   = s2[0];
            end
            5'd15: begin
                alu_res = {s2[MSB-1:0], c_in};
                alu_c   = s2[MSB];
            end
            default: begin
                alu_res = '0;
                alu_c   = 1'b0;
            end
        endcase
    end

    // One mul/div step. Multiply: a_q holds the running high half, b_q the
    // multiplier shifting out as product low bits shift in. Divide: a_q is
    // the partial remainder, b_q the dividend turning into the quotient.
    // The shifted remainder is always below 2*divisor, so the borrow bit of
    // the difference alone decides whether the subtraction is kept; with a
    // zero divisor every step keeps it, giving all-ones / dividend.
    always_comb begin
        mul_sum  = {1'b0, a_q} + (b_q[0] ? {1'b0, opd_q} : {(WIDTH+1){1'b0}});
        mul_hi_n = mul_sum[WIDTH:1];
        mul_lo_n = {mul_sum[0], b_q[MSB:1]};
        div_sh   = {a_q, b_q[MSB]};
        div_diff = div_sh - {1'b0, opd_q};
        div_ge   = ~div_diff[WIDTH];
        div_r_n  = div_ge ? div_diff[MSB:0] : div_sh[MSB:0];
        div_q_n  = {b_q[MSB-1:0], div_ge};
        md_res   = '0;
        md_c     = 1'b0;
        case (md_sel_q)
            2'd0: begin
                md_res = mul_lo_n;
                md_c   = |mul_hi_n;
            end
            2'd1: begin
                md_res = mul_hi_n;
                md_c   = |mul_hi_n;
            end
            2'd2: begin
                md_res = div_q_n;
                md_c   = ~|opd_q;
            end
            default: begin
                md_res = div_r_n;
                md_c   = ~|opd_q;
            end
        endcase
    end

    // Sequencing: accept in IDLE, step in BUSY, hold in DONE.
    // Requests are only looked at in IDLE, so a request presented in the
    // cycle DONE retires waits for the following cycle.
    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        flags_d  = flags_q;
        md_sel_d = md_sel_q;
        bubble_d = bubble_q;
        opd_d    = opd_q;
        a_d      = a_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    md_sel_d = bus.fn[1:0];
                    bubble_d = bus.bubble;
                    if (bus.fn[4:2] == 3'b100) begin
                        state_d = BUSY;
                        opd_d   = s1;
                        a_d     = '0;
                        b_d     = s2;
                        cnt_d   = CW'(WIDTH - 1);
                    end else begin
                        state_d  = DONE;
                        result_d = alu_res;
                        if (!bus.bubble) begin
                            flags_d = {alu_o, alu_res[MSB], ~|alu_res, alu_c};
                        end
                    end
                end
            end
            BUSY: begin
                if (md_sel_q[1]) begin
                    a_d = div_r_n;
                    b_d = div_q_n;
                end else begin
                    a_d = mul_hi_n;
                    b_d = mul_lo_n;
                end
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d  = DONE;
                    result_d = md_res;
                    if (!bubble_q) begin
                        flags_d = {1'b0, md_res[MSB], ~|md_res, md_c};
                    end
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            result_q <= '0;
            flags_q  <= '0;
            md_sel_q <= '0;
            bubble_q <= 1'b0;
            opd_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            md_sel_q <= md_sel_d;
            bubble_q <= bubble_d;
            opd_q    <= opd_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.result    = result_q;
    assign bus.flags     = flags_q;

endmodule
